// File: rtl/qam16_pkg.sv
// Constants and types shared by the 16-QAM modulator and demodulator.
package qam16_pkg;

  localparam int SAMPLE_W       = 10;
  localparam int PROD_W         = 20;
  localparam int THRESH_DEFAULT = 1390000;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DUMP  = 2'b10
  } demod_state_t;

endpackage

// File: rtl/qam16_slicer.sv
// Per-axis 4-level decision on an integrated sum, mapped to two bits.
// QAM16_DEMOD_GRAY_EN selects Gray mapping; otherwise natural binary.
module qam16_slicer
  import qam16_pkg::*;
#(
  parameter int SUM_W  = 25,
  parameter int THRESH = THRESH_DEFAULT
) (
  input  logic signed [SUM_W-1:0] sum,
  output logic        [1:0]       bits
);

  localparam logic signed [SUM_W-1:0] TH_POS = SUM_W'(THRESH);
  localparam logic signed [SUM_W-1:0] TH_NEG = SUM_W'(-THRESH);

  logic [1:0] level_s;

  // Level index 0..3 stands for amplitudes -3, -1, +1, +3.
  always_comb begin
    level_s = 2'd0;
    if (sum >= TH_POS) begin
      level_s = 2'd3;
    end else if (!sum[SUM_W-1]) begin
      level_s = 2'd2;
    end else if (sum >= TH_NEG) begin
      level_s = 2'd1;
    end else begin
      level_s = 2'd0;
    end
  end

`ifdef QAM16_DEMOD_GRAY_EN
  assign bits = {level_s[1], level_s[1] ^ level_s[0]};
`else
  assign bits = level_s;
`endif

endmodule

// File: rtl/qam16_demod.sv
// Coherent 16-QAM demodulator: mix with local carrier, integrate-and-dump
// over SPS samples, slice both axes. Mapping chosen by QAM16_DEMOD_GRAY_EN.
module qam16_demod
  import qam16_pkg::*;
#(
  parameter int SPS    = 16,
  parameter int THRESH = THRESH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] adc_data,
  input  logic                       nco_valid,
  input  logic signed [SAMPLE_W-1:0] nco_sin,
  input  logic signed [SAMPLE_W-1:0] nco_cos,
  input  logic                       sym_sync,
  output logic                       sym_valid,
  output logic [3:0]                 sym_bits
);

  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = PROD_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);

  demod_state_t               state_r, state_next_s;
  logic [CNT_W-1:0]           cnt_r, cnt_next_s;
  logic                       accept_s, take_s, first_s, last_s;
  logic signed [PROD_W-1:0]   prod_i_r, prod_q_r;
  logic                       prod_vld_r, prod_first_r, prod_last_r;
  logic signed [ACC_W-1:0]    acc_i_r, acc_q_r;
  logic                       dump_vld_r;
  logic [1:0]                 bits_i_s, bits_q_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // A sync always restarts the symbol; the sample taking it is sample 0.
  always_comb begin
    accept_s     = in_valid & nco_valid;
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    take_s       = 1'b0;
    first_s      = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (sym_sync) begin
          state_next_s = ACCUM;
          take_s       = accept_s;
          first_s      = accept_s;
          cnt_next_s   = accept_s ? CNT_ONE : CNT_ZERO;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCUM, DUMP: begin
        if (sym_sync) begin
          state_next_s = ACCUM;
          take_s       = accept_s;
          first_s      = accept_s;
          cnt_next_s   = accept_s ? CNT_ONE : CNT_ZERO;
        end else if (accept_s) begin
          take_s  = 1'b1;
          first_s = (cnt_r == CNT_ZERO);
          if (cnt_r == CNT_LAST) begin
            last_s       = 1'b1;
            state_next_s = DUMP;
            cnt_next_s   = CNT_ZERO;
          end else begin
            state_next_s = ACCUM;
            cnt_next_s   = cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = ACCUM;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_i_r     <= '0;
      prod_q_r     <= '0;
      prod_vld_r   <= 1'b0;
      prod_first_r <= 1'b0;
      prod_last_r  <= 1'b0;
    end else begin
      prod_vld_r   <= take_s;
      prod_first_r <= first_s;
      prod_last_r  <= last_s;
      if (take_s) begin
        prod_i_r <= PROD_W'(adc_data) * PROD_W'(nco_cos);
        prod_q_r <= -(PROD_W'(adc_data) * PROD_W'(nco_sin));
      end
    end
  end

  // Sample 0 overwrites the sums, which is what discards a truncated symbol.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_r    <= '0;
      acc_q_r    <= '0;
      dump_vld_r <= 1'b0;
    end else begin
      dump_vld_r <= prod_vld_r & prod_last_r;
      if (prod_vld_r) begin
        acc_i_r <= prod_first_r ? ACC_W'(prod_i_r) : acc_i_r + ACC_W'(prod_i_r);
        acc_q_r <= prod_first_r ? ACC_W'(prod_q_r) : acc_q_r + ACC_W'(prod_q_r);
      end
    end
  end

  qam16_slicer #(.SUM_W(ACC_W), .THRESH(THRESH)) u_slicer_i (.sum(acc_i_r), .bits(bits_i_s));
  qam16_slicer #(.SUM_W(ACC_W), .THRESH(THRESH)) u_slicer_q (.sum(acc_q_r), .bits(bits_q_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_valid <= 1'b0;
      sym_bits  <= 4'b0000;
    end else begin
      sym_valid <= dump_vld_r;
      if (dump_vld_r) begin
        sym_bits <= {bits_i_s, bits_q_s};
      end
    end
  end

endmodule
